// File: rtl/led_seq_pkg.sv
// Shared encodings and helpers for the LED pattern sequencer.
// Pattern indices, mode encodings and enabled-pattern search functions.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_MANUAL = 2'd3
    } mode_e;

    localparam int NUM_PAT = 6;

    localparam logic [2:0] P_WALKL = 3'd0;
    localparam logic [2:0] P_WALKR = 3'd1;
    localparam logic [2:0] P_FILLU = 3'd2;
    localparam logic [2:0] P_FILLD = 3'd3;
    localparam logic [2:0] P_BLINK = 3'd4;
    localparam logic [2:0] P_CONV  = 3'd5;

    // Width of the step index: enough for the longest pattern.
    function automatic int step_width(input int led_w, input int blinks);
        int longest;
        longest = (led_w > 2 * blinks) ? led_w : 2 * blinks;
        return $clog2(longest);
    endfunction

    function automatic logic [2:0] lowest_enabled(input logic [NUM_PAT-1:0] en);
        logic [2:0] res;
        res = 3'd0;
        for (int i = NUM_PAT - 1; i >= 0; i--) begin
            if (en[i]) res = 3'(i);
        end
        return res;
    endfunction

    // Ascending circular search; falls back to the lowest enabled index
    // (which may be cur itself when it is the only one enabled).
    function automatic logic [2:0] next_enabled(input logic [2:0] cur,
                                                input logic [NUM_PAT-1:0] en);
        logic [NUM_PAT-1:0] above;
        above = '0;
        for (int i = 0; i < NUM_PAT; i++) begin
            if (i > int'(cur)) above[i] = en[i];
        end
        return (|above) ? lowest_enabled(above) : lowest_enabled(en);
    endfunction

endpackage

// File: rtl/led_seq_engine_if.sv
// Control/status bundle between the LED sequencer and its host logic.
// The host drives mode, enable mask and step; the sequencer returns LED state.
interface led_seq_engine_if #(
    parameter int LED_W  = 18,
    parameter int BLINKS = 3,
    parameter int SW     = led_seq_pkg::step_width(LED_W, BLINKS)
);
    logic [1:0]       MODE;
    logic [5:0]       PAT_EN;
    logic             STEP;
    logic [LED_W-1:0] LED;
    logic [2:0]       PAT_IDX;
    logic [SW-1:0]    STEP_IDX;
    logic             ACTIVE;
    logic             PAT_DONE;
    logic             WRAP;

    modport master (
        output MODE, PAT_EN, STEP,
        input  LED, PAT_IDX, STEP_IDX, ACTIVE, PAT_DONE, WRAP
    );

    modport slave (
        input  MODE, PAT_EN, STEP,
        output LED, PAT_IDX, STEP_IDX, ACTIVE, PAT_DONE, WRAP
    );
endinterface

// File: rtl/led_pat_gen.sv
// Combinational pattern table: (pattern, step) -> LED bar image and a
// flag marking the final step of that pattern.
module led_pat_gen
    import led_seq_pkg::*;
#(
    parameter int LED_W  = 18,
    parameter int BLINKS = 3,
    parameter int SW     = step_width(LED_W, BLINKS)
) (
    input  logic [2:0]       pat,
    input  logic [SW-1:0]    step,
    output logic [LED_W-1:0] led,
    output logic             last_step
);
    localparam int LEN_BAR   = LED_W;
    localparam int LEN_BLINK = 2 * BLINKS;
    localparam int LEN_CONV  = (LED_W + 1) / 2;

    logic [LED_W-1:0] walkl;
    logic [LED_W-1:0] walkr;
    logic [LED_W-1:0] fillu;
    logic [LED_W-1:0] filld;
    logic [LED_W-1:0] conv;

    // Each bit decides for itself whether it is lit, avoiding wide shifters.
    genvar gi;
    generate
        for (gi = 0; gi < LED_W; gi++) begin : g_bit
            assign walkl[gi] = (int'(step) == gi);
            assign walkr[gi] = (int'(step) == LED_W - 1 - gi);
            assign fillu[gi] = (int'(step) >= gi);
            assign filld[gi] = (int'(step) >= LED_W - 1 - gi);
            assign conv[gi]  = (int'(step) == gi) || (int'(step) == LED_W - 1 - gi);
        end
    endgenerate

    always_comb begin
        led       = '0;
        last_step = 1'b1;
        case (pat)
            P_WALKL: begin led = walkl; last_step = (int'(step) == LEN_BAR - 1);   end
            P_WALKR: begin led = walkr; last_step = (int'(step) == LEN_BAR - 1);   end
            P_FILLU: begin led = fillu; last_step = (int'(step) == LEN_BAR - 1);   end
            P_FILLD: begin led = filld; last_step = (int'(step) == LEN_BAR - 1);   end
            P_BLINK: begin
                led       = {LED_W{~step[0]}};
                last_step = (int'(step) == LEN_BLINK - 1);
            end
            P_CONV:  begin led = conv;  last_step = (int'(step) == LEN_CONV - 1);  end
            default: begin led = '0;    last_step = 1'b1;                          end
        endcase
    end
endmodule

// File: rtl/led_seq_engine.sv
// LED pattern sequencer: dwell timing, step/pattern advance, enable-mask
// search and single-cycle boundary pulses, driving an LED_W-bit bar.
module led_seq_engine
    import led_seq_pkg::*;
#(
    parameter int LED_W  = 18,
    parameter int DWELL  = 1,
    parameter int BLINKS = 3
) (
    input logic               PULSE,
    input logic               RESET_N,
    led_seq_engine_if.slave   bus
);
    localparam int SW = step_width(LED_W, BLINKS);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic          active_reg, active_next;
    logic [2:0]    pat_reg, pat_next;
    logic [SW-1:0] step_reg, step_next;
    logic [DW-1:0] dwell_reg, dwell_next;
    logic          done_reg, done_next;
    logic          wrap_reg, wrap_next;
    mode_e         mode_prev_reg, mode_prev_next;

    mode_e            mode_in;
    logic             go_idle;
    logic             advance;
    logic [2:0]       pat_following;
    logic [LED_W-1:0] gen_led;
    logic             last_step;

    led_pat_gen #(.LED_W(LED_W), .BLINKS(BLINKS), .SW(SW)) u_pat_gen (
        .pat       (pat_reg),
        .step      (step_reg),
        .led       (gen_led),
        .last_step (last_step)
    );

    always_ff @(posedge PULSE or negedge RESET_N) begin
        if (!RESET_N) begin
            active_reg    <= 1'b0;
            pat_reg       <= 3'd0;
            step_reg      <= '0;
            dwell_reg     <= '0;
            done_reg      <= 1'b0;
            wrap_reg      <= 1'b0;
            mode_prev_reg <= MODE_OFF;
        end else begin
            active_reg    <= active_next;
            pat_reg       <= pat_next;
            step_reg      <= step_next;
            dwell_reg     <= dwell_next;
            done_reg      <= done_next;
            wrap_reg      <= wrap_next;
            mode_prev_reg <= mode_prev_next;
        end
    end

    always_comb begin
        active_next    = active_reg;
        pat_next       = pat_reg;
        step_next      = step_reg;
        dwell_next     = dwell_reg;
        done_next      = 1'b0;
        wrap_next      = 1'b0;
        mode_in        = mode_e'(bus.MODE);
        mode_prev_next = mode_in;
        advance        = 1'b0;
        pat_following  = next_enabled(pat_reg, bus.PAT_EN);
        // An empty mask only stops a running sequence at its next boundary.
        go_idle        = (mode_in == MODE_OFF) || (!active_reg && bus.PAT_EN == '0);

        if (go_idle) begin
            active_next = 1'b0;
            step_next   = '0;
            dwell_next  = '0;
            pat_next    = lowest_enabled(bus.PAT_EN);
        end else if (!active_reg) begin
            active_next = 1'b1;
            step_next   = '0;
            dwell_next  = '0;
            pat_next    = lowest_enabled(bus.PAT_EN);
        end else if (mode_in != mode_prev_reg) begin
            dwell_next = '0;
        end else begin
            if (mode_in == MODE_MANUAL) begin
                dwell_next = '0;
                advance    = bus.STEP;
            end else if (dwell_reg == DW'(DWELL - 1)) begin
                dwell_next = '0;
                advance    = 1'b1;
            end else begin
                dwell_next = dwell_reg + 1'b1;
            end

            if (advance) begin
                if (!last_step) begin
                    step_next = step_reg + 1'b1;
                end else if (bus.PAT_EN == '0) begin
                    active_next = 1'b0;
                    step_next   = '0;
                    dwell_next  = '0;
                    pat_next    = P_WALKL;
                end else begin
                    step_next = '0;
                    done_next = 1'b1;
                    if (mode_in != MODE_HOLD) begin
                        pat_next  = pat_following;
                        wrap_next = (pat_following <= pat_reg);
                    end
                end
            end
        end
    end

    assign bus.LED      = active_reg ? gen_led : '0;
    assign bus.PAT_IDX  = pat_reg;
    assign bus.STEP_IDX = step_reg;
    assign bus.ACTIVE   = active_reg;
    assign bus.PAT_DONE = done_reg;
    assign bus.WRAP     = wrap_reg;
endmodule

// File: tb/tb_led_seq_engine.sv
// Scoreboard bench for led_seq_engine (LED_W=8, DWELL=2, BLINKS=3): the driver
// queues the expected post-edge state per cycle, a monitor pops and compares.
module tb_led_seq_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    led_seq_engine_if #(.LED_W(8), .BLINKS(3)) bus ();

    led_seq_engine #(.LED_W(8), .DWELL(2), .BLINKS(3)) dut (
        .PULSE   (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] led;
        logic [2:0] pat;
        logic [2:0] step;
        logic       act;
        logic       done;
        logic       wrap;
        bit         chk_pulse;
        string      tag;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [7:0] walk  [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] walkr [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] fill  [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    logic [7:0] blink [6] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [7:0] conv  [4] = '{8'h81, 8'h42, 8'h24, 8'h18};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and queue the state expected after the next rising edge.
    task automatic cyc(input logic r, input logic [1:0] m, input logic [5:0] en, input logic st,
                       input logic [7:0] led, input logic [2:0] pat, input logic [2:0] stp,
                       input logic act, input logic done, input logic wrap,
                       input string tag, input bit chk_pulse = 1'b1);
        exp_t e;
        @(negedge clk);
        rst_n      = r;
        bus.MODE   = m;
        bus.PAT_EN = en;
        bus.STEP   = st;
        e.led = led; e.pat = pat; e.step = stp; e.act = act;
        e.done = done; e.wrap = wrap; e.chk_pulse = chk_pulse; e.tag = tag;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                $display("txn %s led=%02h pat=%0d step=%0d act=%0b done=%0b wrap=%0b",
                         e.tag, bus.LED, bus.PAT_IDX, bus.STEP_IDX, bus.ACTIVE, bus.PAT_DONE, bus.WRAP);
                check({e.tag, ".led"},  32'(bus.LED),      32'(e.led));
                check({e.tag, ".pat"},  32'(bus.PAT_IDX),  32'(e.pat));
                check({e.tag, ".step"}, 32'(bus.STEP_IDX), 32'(e.step));
                check({e.tag, ".act"},  32'(bus.ACTIVE),   32'(e.act));
                if (e.chk_pulse) begin
                    check({e.tag, ".done"}, 32'(bus.PAT_DONE), 32'(e.done));
                    check({e.tag, ".wrap"}, 32'(bus.WRAP),     32'(e.wrap));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.MODE = 2'd0; bus.PAT_EN = 6'd0; bus.STEP = 1'b0;

        // 1: reset, then P0 alone in AUTO, wraps back onto itself
        cyc(1'b0, 2'd1, 6'h01, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "t1_reset");
        for (int k = 0; k < 8; k++)
            for (int d = 0; d < 2; d++)
                cyc(1'b1, 2'd1, 6'h01, 1'b0, walk[k], 3'd0, 3'(k), 1'b1, 1'b0, 1'b0, "t1_walk");
        cyc(1'b1, 2'd1, 6'h01, 1'b0, 8'h01, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, "t1_wrap");
        cyc(1'b1, 2'd1, 6'h01, 1'b0, 8'h01, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, "t1_after");

        // 2: blink then converge, wrap only on P5->P4
        cyc(1'b1, 2'd0, 6'h01, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "t2_idle");
        for (int k = 0; k < 6; k++)
            for (int d = 0; d < 2; d++)
                cyc(1'b1, 2'd1, 6'h30, 1'b0, blink[k], 3'd4, 3'(k), 1'b1, 1'b0, 1'b0, "t2_blink");
        for (int k = 0; k < 4; k++)
            for (int d = 0; d < 2; d++)
                cyc(1'b1, 2'd1, 6'h30, 1'b0, conv[k], 3'd5, 3'(k), 1'b1,
                    (k == 0 && d == 0), 1'b0, "t2_conv");
        cyc(1'b1, 2'd1, 6'h30, 1'b0, 8'hFF, 3'd4, 3'd0, 1'b1, 1'b1, 1'b1, "t2_wrap");
        cyc(1'b1, 2'd1, 6'h30, 1'b0, 8'hFF, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0, "t2_after");

        // 3: switch to HOLD at P2 step 3, loops back to step 0 of P2
        cyc(1'b1, 2'd0, 6'h04, 1'b0, 8'h00, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, "t3_idle");
        for (int k = 0; k < 3; k++)
            for (int d = 0; d < 2; d++)
                cyc(1'b1, 2'd1, 6'h04, 1'b0, fill[k], 3'd2, 3'(k), 1'b1, 1'b0, 1'b0, "t3_auto");
        cyc(1'b1, 2'd1, 6'h04, 1'b0, 8'h0F, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0, "t3_auto");
        cyc(1'b1, 2'd2, 6'h04, 1'b0, 8'h0F, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0, "t3_modechg");
        cyc(1'b1, 2'd2, 6'h04, 1'b0, 8'h0F, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0, "t3_hold");
        for (int k = 4; k < 8; k++)
            for (int d = 0; d < 2; d++)
                cyc(1'b1, 2'd2, 6'h04, 1'b0, fill[k], 3'd2, 3'(k), 1'b1, 1'b0, 1'b0, "t3_hold");
        cyc(1'b1, 2'd2, 6'h04, 1'b0, 8'h01, 3'd2, 3'd0, 1'b1, 1'b1, 1'b0, "t3_loop");
        cyc(1'b1, 2'd2, 6'h04, 1'b0, 8'h01, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, "t3_after");

        // 4: MANUAL stepping of P1, holds between pulses
        cyc(1'b1, 2'd0, 6'h02, 1'b0, 8'h00, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, "t4_idle");
        cyc(1'b1, 2'd3, 6'h02, 1'b0, 8'h80, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, "t4_start");
        for (int p = 1; p <= 9; p++) begin
            cyc(1'b1, 2'd3, 6'h02, 1'b1, walkr[p % 8], 3'd1, 3'(p % 8), 1'b1,
                (p == 8), (p == 8), "t4_step");
            for (int w = 0; w < 5; w++)
                cyc(1'b1, 2'd3, 6'h02, 1'b0, walkr[p % 8], 3'd1, 3'(p % 8), 1'b1,
                    1'b0, 1'b0, "t4_wait");
        end

        // 5: mask cleared mid-pattern lets P0 finish; MODE=0 stops at once
        cyc(1'b1, 2'd0, 6'h01, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "t5_idle");
        cyc(1'b1, 2'd1, 6'h01, 1'b0, 8'h01, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, "t5_run");
        cyc(1'b1, 2'd1, 6'h01, 1'b0, 8'h01, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, "t5_run");
        cyc(1'b1, 2'd1, 6'h01, 1'b0, 8'h02, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, "t5_run");
        cyc(1'b1, 2'd1, 6'h01, 1'b0, 8'h02, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, "t5_run");
        for (int k = 2; k < 8; k++)
            for (int d = 0; d < 2; d++)
                cyc(1'b1, 2'd1, 6'h00, 1'b0, walk[k], 3'd0, 3'(k), 1'b1, 1'b0, 1'b0, "t5_drain");
        cyc(1'b1, 2'd1, 6'h00, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "t5_stop", 1'b0);
        cyc(1'b1, 2'd1, 6'h00, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "t5_stopped");
        cyc(1'b1, 2'd1, 6'h01, 1'b0, 8'h01, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, "t5_rerun");
        cyc(1'b1, 2'd1, 6'h01, 1'b0, 8'h01, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, "t5_rerun");
        cyc(1'b1, 2'd1, 6'h01, 1'b0, 8'h02, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, "t5_rerun");
        cyc(1'b1, 2'd0, 6'h01, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "t5_off");

        // 6: asynchronous reset in the middle of a step, then restart
        cyc(1'b1, 2'd1, 6'h08, 1'b0, 8'h80, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, "t6_run");
        cyc(1'b1, 2'd1, 6'h08, 1'b0, 8'h80, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, "t6_run");
        cyc(1'b1, 2'd1, 6'h08, 1'b0, 8'hC0, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, "t6_run");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        $display("txn t6_async led=%02h pat=%0d step=%0d act=%0b", bus.LED, bus.PAT_IDX, bus.STEP_IDX, bus.ACTIVE);
        check("t6_async.led",  32'(bus.LED),      32'h0);
        check("t6_async.act",  32'(bus.ACTIVE),   32'h0);
        check("t6_async.pat",  32'(bus.PAT_IDX),  32'h0);
        check("t6_async.step", 32'(bus.STEP_IDX), 32'h0);
        check("t6_async.done", 32'(bus.PAT_DONE), 32'h0);
        check("t6_async.wrap", 32'(bus.WRAP),     32'h0);
        cyc(1'b0, 2'd1, 6'h0C, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, "t6_held");
        cyc(1'b1, 2'd1, 6'h0C, 1'b0, 8'h01, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, "t6_restart");
        cyc(1'b1, 2'd1, 6'h0C, 1'b0, 8'h01, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, "t6_restart");
        cyc(1'b1, 2'd1, 6'h0C, 1'b0, 8'h03, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0, "t6_restart");

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
